// File: rtl/divide_sched_pkg.sv
// divide_sched_pkg
// Shared constants, tag record and frame helper for the divide scheduler.
// The frame is FRAME_LEN cycles long. Phase PHASE_LOAD is the cycle that
// ends with the Divide loading its operands. PHASE_CAPTURE is the cycle
// that ends with the scheduler capturing the quotient. PHASE_ARB is the
// only cycle in which a requester can be granted.
package divide_sched_pkg;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int FRAME_LEN = 33;

    localparam logic [5:0] PHASE_LOAD    = 6'd0;
    localparam logic [5:0] PHASE_CAPTURE = 6'd1;
    localparam logic [5:0] PHASE_ARB     = 6'(FRAME_LEN - 1);

    // Bookkeeping that travels with one division through the pipeline
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            div_zero;
        logic            ovf;
    } sched_tag_t;

    localparam sched_tag_t TAG_IDLE = '0;

    // Frame counter successor: 0..PHASE_ARB then wrap to PHASE_LOAD
    function automatic logic [5:0] next_phase(input logic [5:0] p);
        if (p >= PHASE_ARB) begin
            return PHASE_LOAD;
        end else begin
            return p + 6'd1;
        end
    endfunction

endpackage

// File: rtl/divide_scheduler_divide.sv
// divide_scheduler_divide
// Free-running 64/32 restoring divider, two quotient bits per cycle.
// Each frame has a Start cycle (count 0) whose closing edge loads A and B.
// It then runs 32 compute cycles. The low 32 quotient bits are placed on Y
// at the edge that ends the last compute cycle, and Y holds through the
// whole following frame.
// Reset is resynchronised by one flop. The count is forced to the Start
// value while that flop is high, so the first cycle after it clears is a
// Start cycle.
// Ports: Clk, Reset (active high), A[63:0] dividend, B[31:0] divisor,
//        Y[31:0] quotient (low 32 bits of floor(A/B); all ones when B is 0).
module divide_scheduler_divide
    import divide_sched_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] A,
    input  logic [31:0] B,
    output logic [31:0] Y
);

    logic        rst_q_r;
    logic [5:0]  cnt_r;
    logic [31:0] rem_r;
    logic [63:0] quo_r;
    logic [31:0] div_r;
    logic [31:0] y_r;
    logic [95:0] step1_s;
    logic [95:0] step2_s;

    // One restoring step: shift a dividend bit into the remainder, subtract if it fits
    function automatic logic [95:0] div_step(input logic [31:0] rem,
                                             input logic [63:0] quo,
                                             input logic [31:0] d);
        logic [32:0] shifted;
        logic [32:0] diff;
        shifted = {rem, quo[63]};
        diff    = shifted - {1'b0, d};
        if (shifted >= {1'b0, d}) begin
            return {diff[31:0], quo[62:0], 1'b1};
        end else begin
            return {shifted[31:0], quo[62:0], 1'b0};
        end
    endfunction

    // Two chained restoring steps per clock
    always_comb begin
        step1_s = div_step(rem_r, quo_r, div_r);
        step2_s = div_step(step1_s[95:64], step1_s[63:0], div_r);
    end

    // Reset resynchroniser and frame counter
    always_ff @(posedge Clk) begin
        rst_q_r <= Reset;
        if (rst_q_r) begin
            cnt_r <= PHASE_LOAD;
        end else begin
            cnt_r <= next_phase(cnt_r);
        end
    end

    // Operand load, iteration and result latch
    always_ff @(posedge Clk) begin
        if (cnt_r == PHASE_LOAD) begin
            rem_r <= 32'd0;
            quo_r <= A;
            div_r <= B;
        end else begin
            rem_r <= step2_s[95:64];
            quo_r <= step2_s[63:0];
        end
        if (cnt_r == PHASE_ARB) begin
            y_r <= step2_s[31:0];
        end
    end

    assign Y = y_r;

endmodule

// File: rtl/divide_scheduler.sv
// divide_scheduler
// Shares one free-running divider among NUM_REQ requesters, one division
// per 33-cycle frame. Arbitration happens only in the last cycle of a frame
// (PHASE_ARB), round-robin from the requester after the last one granted.
// A tag follows each division through three stages: the grant stage, the
// in-flight stage and the output stage. Its result is strobed in phase 2
// of the frame after the one in which the divider computed it, 36 cycles
// after the grant.
// Ports: Clk; nReset (async, active low); Req/ReqA/ReqB requests and
//        operands; Grant one-hot acceptance pulse; ResValid/ResId/Res/
//        ResDivZero/ResOvf result strobe, owner and flags.
module divide_scheduler #(
    parameter int NUM_REQ = divide_sched_pkg::NUM_REQ
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [NUM_REQ-1:0]     Req,
    input  logic [64*NUM_REQ-1:0]  ReqA,
    input  logic [32*NUM_REQ-1:0]  ReqB,
    output logic [NUM_REQ-1:0]     Grant,
    output logic                   ResValid,
    output logic [1:0]             ResId,
    output logic [31:0]            Res,
    output logic                   ResDivZero,
    output logic                   ResOvf
);

    import divide_sched_pkg::*;

    logic [5:0]         phase_r;
    logic [ID_W-1:0]    last_r;
    logic [63:0]        op_a_r;
    logic [31:0]        op_b_r;
    sched_tag_t         grant_tag_r;
    sched_tag_t         flight_tag_r;
    sched_tag_t         out_tag_r;
    logic               res_valid_r;
    logic [31:0]        res_r;
    logic [1:0]         res_id_r;
    logic               res_dz_r;
    logic               res_ovf_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_id_s;
    logic               grant_any_s;
    logic [63:0]        sel_a_s;
    logic [31:0]        sel_b_s;
    logic [31:0]        div_y_s;
    logic               div_reset_s;
    logic               capture_s;

    assign div_reset_s = ~nReset;

    divide_scheduler_divide u_divide (
        .Clk   (Clk),
        .Reset (div_reset_s),
        .A     (op_a_r),
        .B     (op_b_r),
        .Y     (div_y_s)
    );

    // Round-robin arbiter, live only in the arbitration cycle
    always_comb begin
        logic [ID_W-1:0] cand;
        cand        = '0;
        grant_s     = '0;
        grant_id_s  = '0;
        grant_any_s = 1'b0;
        if (nReset && (phase_r == PHASE_ARB)) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand = last_r + ID_W'(off);
                if (!grant_any_s && Req[cand]) begin
                    grant_any_s = 1'b1;
                    grant_id_s  = cand;
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
            grant_s[grant_id_s] = grant_any_s;
        end else begin
            grant_s = '0;
        end
    end

    // Operands of the requester currently winning arbitration
    always_comb begin
        sel_a_s = ReqA[64*grant_id_s +: 64];
        sel_b_s = ReqB[32*grant_id_s +: 32];
    end

    assign capture_s = (phase_r == PHASE_CAPTURE) && out_tag_r.valid;

    // Frame counter and round-robin pointer
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            phase_r <= PHASE_ARB;
            last_r  <= ID_W'(NUM_REQ - 1);
        end else begin
            phase_r <= next_phase(phase_r);
            if (grant_any_s) begin
                last_r <= grant_id_s;
            end
        end
    end

    // Operand registers and tag pipeline (grant -> in-flight -> output)
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            op_a_r       <= 64'd0;
            op_b_r       <= 32'd0;
            grant_tag_r  <= TAG_IDLE;
            flight_tag_r <= TAG_IDLE;
            out_tag_r    <= TAG_IDLE;
        end else begin
            if (phase_r == PHASE_ARB) begin
                // An empty frame still writes an invalid tag so nothing is strobed
                grant_tag_r.valid    <= grant_any_s;
                grant_tag_r.id       <= grant_id_s;
                grant_tag_r.div_zero <= (sel_b_s == 32'd0);
                grant_tag_r.ovf      <= (sel_a_s[63:32] >= sel_b_s);
                if (grant_any_s) begin
                    op_a_r <= sel_a_s;
                    op_b_r <= sel_b_s;
                end
            end
            if (phase_r == PHASE_LOAD) begin
                out_tag_r    <= flight_tag_r;
                flight_tag_r <= grant_tag_r;
            end
        end
    end

    // Result registers; only touched on a valid capture so they hold between strobes
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            res_valid_r <= 1'b0;
            res_r       <= 32'd0;
            res_id_r    <= 2'd0;
            res_dz_r    <= 1'b0;
            res_ovf_r   <= 1'b0;
        end else begin
            res_valid_r <= capture_s;
            if (capture_s) begin
                res_r     <= out_tag_r.div_zero ? 32'hFFFF_FFFF : div_y_s;
                res_id_r  <= 2'(out_tag_r.id);
                res_dz_r  <= out_tag_r.div_zero;
                res_ovf_r <= out_tag_r.ovf;
            end
        end
    end

    assign Grant      = grant_s;
    assign ResValid   = res_valid_r;
    assign ResId      = res_id_r;
    assign Res        = res_r;
    assign ResDivZero = res_dz_r;
    assign ResOvf     = res_ovf_r;

endmodule

// File: doc/divide_scheduler.md
DIVIDE_SCHEDULER -- requirements
Module: divide_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have port Clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port nReset  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port Req  input  4  per-requester request, held high with operands stable until granted.
REQ-005 SHALL have port ReqA  input  256  dividends, requester i on bits [64i+63:64i], unsigned.
REQ-006 SHALL have port ReqB  input  128  divisors, requester i on bits [32i+31:32i], unsigned.
REQ-007 SHALL have port Grant  output  4  one-hot acceptance pulse, one cycle; operands consumed at that edge.
REQ-008 SHALL have port ResValid  output  1  one-cycle result strobe.
REQ-009 SHALL have port ResId  output  2  index of requester owning the result.
REQ-010 SHALL have port Res  output  32  quotient, floor(A/B) truncated to 32 bits.
REQ-011 SHALL have port ResDivZero  output  1  B was zero; Res = 0xFFFFFFFF.
REQ-012 SHALL have port ResOvf  output  1  A[63:32] >= B; quotient did not fit, Res is truncated.

Function
REQ-013 SHALL instantiate the existing free-running Divide datapath, Reset driven by ~nReset, A/B driven from internal operand registers OpA/OpB.
REQ-014 SHALL keep a 6-bit frame counter Phase counting 0..32 then wrapping to 0; Phase 0 is the cycle ending in the Divide load edge.
REQ-015 SHALL arbitrate only in cycles with Phase==32: Grant combinational from Req, round-robin, at most one bit set.
REQ-016 SHALL load OpA/OpB, DivZero = (B==0) and Ovf = (A[63:32] >= B) from the granted requester at the edge ending Phase 32.
REQ-017 SHALL give priority starting from the requester after the last granted one; after reset the order is 0,1,2,3.
REQ-018 SHALL mark a frame empty when no Req is high at Phase 32; empty frames produce no ResValid.
REQ-019 SHALL carry a tag (valid, id, DivZero, Ovf) for the in-flight frame, moved to an output tag stage at the edge ending Phase 0 of the next frame.
REQ-020 SHALL register Divide Y into Res at the edge ending Phase 1 and assert ResValid with ResId/flags during Phase 2 if the tag is valid.
REQ-021 SHALL assert ResValid in the 36th cycle after the Grant cycle; throughput one division per 33 cycles.
REQ-022 SHALL hold Res, ResId, ResDivZero and ResOvf stable between strobes.
REQ-023 SHALL ignore Req deasserted before grant (no grant, no result) and Req changes outside Phase 32.
REQ-024 SHALL process a grant and a result strobe of different frames independently in the same frame.

Reset
REQ-025 SHALL, while nReset is low, force Phase=32, Grant=0, ResValid=0, Res=0, ResId=0, ResDivZero=0, ResOvf=0, all tags invalid, round-robin pointer to requester 3.
REQ-026 SHALL align so the first Phase 0 after reset release is the Divide's first Start cycle, given the Divide's 1-cycle reset resynchronisation.
REQ-027 SHALL discard any in-flight division when nReset is asserted mid-frame; no ResValid for it after release.
REQ-028 SHALL require nReset low for at least 2 Clk cycles.

Structure
REQ-029 SHALL place NUM_REQ, FRAME_LEN=33, PHASE_ARB=32, PHASE_CAPTURE=1 and the tag record layout in shared package divide_sched_pkg.
REQ-030 SHALL have the Divide instance as its only sub-module; arbiter, counter and tag pipeline stay inline.

Verification
REQ-031 SHALL check that Req[0], A=100, B=7 gives Grant[0] for one cycle and, 36 cycles later, ResValid with Res=14, ResId=0, flags 0.
REQ-032 SHALL check that Req[2], A=0x0000_0001_0000_0000, B=2 gives Res=0x8000_0000, ResId=2, flags 0.
REQ-033 SHALL check that Req[1], A=5, B=0 gives Res=0xFFFFFFFF, ResDivZero=1, ResOvf=1; Req[3], A=0x0000_0005_0000_0000, B=5 gives ResOvf=1, ResDivZero=0.
REQ-034 SHALL check that all four Req held high from reset give grants 3 then 0? no: 0,1,2,3 in consecutive frames 33 cycles apart, with results in the same ID order, each correct.
REQ-035 SHALL check that nReset pulsed low for 3 cycles at Phase 10 after a grant gives no ResValid for that request, and a new request after release completes with correct latency.
